// File: rtl/gary_pkg.sv
// Shared region codes, FSM encoding and address-field constants for the gary_arb
// chip-bus decoder/arbiter.
package gary_pkg;

   typedef enum logic [2:0] {
      RGN_NONE,
      RGN_CHIP,
      RGN_SLOW,
      RGN_REG,
      RGN_CIA,
      RGN_KICK,
      RGN_BOOT
   } region_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   // address[23:21] and address[23:19] fields
   localparam logic [2:0] HI_LOW   = 3'b000;
   localparam logic [2:0] HI_CIA   = 3'b101;
   localparam logic [2:0] HI_REG   = 3'b110;
   localparam logic [4:0] TOP_SLOW = 5'b11000;
   localparam logic [4:0] TOP_KICK = 5'b11111;

   localparam logic [7:0] TIMEOUT_MAX = 8'd255;

   function automatic logic is_shared(region_t r);
      return (r == RGN_CHIP) || (r == RGN_REG);
   endfunction

   function automatic logic timeout_hit(logic [7:0] count);
      return count == TIMEOUT_MAX;
   endfunction

endpackage

// File: rtl/gary_decode.sv
// Combinational CPU address decode: region code for the arbiter plus the bus select lines.
// Agnus ownership (dma) overrides every select except chip RAM.
module gary_decode
   import gary_pkg::*;
#(
   parameter int CHIP_BLOCKS = 2,
   parameter int SLOW_BLOCKS = 1
)(
   input  logic [11:0] cpuaddress,
   input  logic        dma,
   input  logic        ovl,
   input  logic        boot,
   output region_t     region,
   output logic        selreg,
   output logic        selchip,
   output logic        selslow,
   output logic        selciaa,
   output logic        selciab,
   output logic        selkick,
   output logic        selboot
);

   logic [4:0] top5;
   logic [2:0] top3;
   logic [4:0] slow_ofs;

   assign top5     = cpuaddress[11:7];
   assign top3     = cpuaddress[11:9];
   assign slow_ofs = top5 - TOP_SLOW;

   always_comb begin
      region = RGN_NONE;
      if (top5 == TOP_KICK) begin
         region = RGN_KICK;
      end else if (top3 == HI_LOW) begin
         if (boot && (cpuaddress[8:0] == 9'd0))
            region = RGN_BOOT;
         else if (ovl)
            region = RGN_KICK;
         else if (int'(cpuaddress[8:7]) < CHIP_BLOCKS)
            region = RGN_CHIP;
      end else if (int'(slow_ofs) < SLOW_BLOCKS) begin
         region = RGN_SLOW;
      end else if (top3 == HI_REG) begin
         region = RGN_REG;
      end else if (top3 == HI_CIA) begin
         region = RGN_CIA;
      end
   end

   assign selchip = dma || (region == RGN_CHIP);
   assign selreg  = !dma && (region == RGN_REG);
   assign selslow = !dma && (region == RGN_SLOW);
   assign selkick = !dma && (region == RGN_KICK);
   assign selboot = !dma && (region == RGN_BOOT);
   // both CIAs can be addressed by one access
   assign selciaa = !dma && (region == RGN_CIA) && !cpuaddress[0];
   assign selciab = !dma && (region == RGN_CIA) && !cpuaddress[1];

endmodule

// File: rtl/gary_arb.sv
// gary_arb: chip-bus decoder/arbiter with registered cpureq/cpuack handshake, E-aligned CIA
// access and blitter-nasty starvation relief. Define GARY_ARB_TIMEOUT_EN for a WAIT watchdog.
//
// state   | meaning
// ST_IDLE | nothing in flight; cpureq starts an access
// ST_WAIT | access decoded, waiting for the region's slot rule
// ST_ACK  | one-cycle cpuack (and berr on watchdog expiry); cpureq ignored
module gary_arb
   import gary_pkg::*;
#(
   parameter int CHIP_BLOCKS = 2,
   parameter int SLOW_BLOCKS = 1,
   parameter int NASTY_MAX   = 3
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        e,
   input  logic [11:0] cpuaddress,
   input  logic        cpureq,
   input  logic        cpurd,
   input  logic        cpuhwr,
   input  logic        cpulwr,
   output logic        cpuack,
   input  logic        dma,
   input  logic        dmawr,
   input  logic        dmapri,
   input  logic        ovl,
   input  logic        boot,
   output logic        rd,
   output logic        hwr,
   output logic        lwr,
   output logic        selreg,
   output logic        selchip,
   output logic        selslow,
   output logic        selciaa,
   output logic        selciab,
   output logic        selkick,
   output logic        selboot,
   output logic        berr
);

   region_t    region;
   logic [1:0] state, state_nxt;
   logic       e_d, e_rise, ciadone;
   logic [3:0] nasty;
   logic       nasty_full, ack_ok, ack_go, tmo_hit;

   gary_decode #(
      .CHIP_BLOCKS (CHIP_BLOCKS),
      .SLOW_BLOCKS (SLOW_BLOCKS)
   ) u_decode (
      .cpuaddress (cpuaddress),
      .dma        (dma),
      .ovl        (ovl),
      .boot       (boot),
      .region     (region),
      .selreg     (selreg),
      .selchip    (selchip),
      .selslow    (selslow),
      .selciaa    (selciaa),
      .selciab    (selciab),
      .selkick    (selkick),
      .selboot    (selboot)
   );

   assign rd  = dma ? ~dmawr : (cpurd  & cpureq);
   assign hwr = dma ?  dmawr : (cpuhwr & cpureq);
   assign lwr = dma ?  dmawr : (cpulwr & cpureq);

   assign e_rise     = e & ~e_d;
   assign nasty_full = (nasty == 4'(NASTY_MAX));
   assign cpuack     = (state == ST_ACK);

   always_comb begin
      ack_ok = 1'b1;
      case (region)
         RGN_CHIP, RGN_REG: ack_ok = !dma && (!dmapri || nasty_full);
         RGN_SLOW:          ack_ok = !dma;
         RGN_CIA:           ack_ok = !dma && e && !ciadone;
         default:           ack_ok = 1'b1;
      endcase
   end

   always_comb begin
      state_nxt = state;
      ack_go    = 1'b0;
      case (state)
         ST_IDLE: if (cpureq) state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (!cpureq) begin
               state_nxt = ST_IDLE;
            end else if (ack_ok || tmo_hit) begin
               state_nxt = ST_ACK;
               ack_go    = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) e_d <= 1'b0;
      else       e_d <= e;
   end

   // one CIA access per E-high period; a new period starts with e low or a fresh rising edge
   always_ff @(posedge clk) begin
      if (reset)
         ciadone <= 1'b0;
      else if (ack_go && ack_ok && (region == RGN_CIA))
         ciadone <= 1'b1;
      else if (!e || e_rise)
         ciadone <= 1'b0;
   end

   // counts free slots lost to blitter priority; saturation forces one CPU slot through
   always_ff @(posedge clk) begin
      if (reset || (state != ST_WAIT) || (state_nxt != ST_WAIT))
         nasty <= 4'd0;
      else if (is_shared(region) && !dma && dmapri && !nasty_full)
         nasty <= nasty + 4'd1;
   end

`ifdef GARY_ARB_TIMEOUT_EN
   logic [7:0] tmo;

   assign tmo_hit = (state == ST_WAIT) && timeout_hit(tmo);

   always_ff @(posedge clk) begin
      if (reset || (state != ST_WAIT) || (state_nxt != ST_WAIT))
         tmo <= 8'd0;
      else
         tmo <= tmo + 8'd1;
   end

   // only a watchdog-forced ack reports a bus error
   always_ff @(posedge clk) begin
      if (reset) berr <= 1'b0;
      else       berr <= ack_go && !ack_ok;
   end
`else
   assign tmo_hit = 1'b0;
   assign berr    = 1'b0;
`endif

endmodule

// File: tb/tb_gary_arb.sv
// Self-checking bench for gary_arb: directed steps then randomized transactions against an
// address-range / slot-counting reference model.
module tb_gary_arb;

   localparam int CHIP_BLOCKS = 2;
   localparam int SLOW_BLOCKS = 1;
   localparam int NASTY_MAX   = 3;

   localparam int R_NONE = 0, R_CHIP = 1, R_SLOW = 2, R_REG = 3, R_CIA = 4, R_KICK = 5, R_BOOT = 6;

`ifdef GARY_ARB_TIMEOUT_EN
   localparam int HOLD = 20;
`else
   localparam int HOLD = 300;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        e = 1'b0;
   logic [11:0] cpuaddress = 12'h000;
   logic        cpureq = 1'b0, cpurd = 1'b0, cpuhwr = 1'b0, cpulwr = 1'b0;
   logic        dma = 1'b0, dmawr = 1'b0, dmapri = 1'b0, ovl = 1'b0, boot = 1'b0;
   logic        cpuack, rd, hwr, lwr, berr;
   logic        selreg, selchip, selslow, selciaa, selciab, selkick, selboot;

   int nchk = 0;
   int nerr = 0;

   // bench-side environment state
   int  cycle = 0;
   int  e_cnt = 0, e_per = 10, e_hi = 1;
   bit  e_run = 1'b1, e_prev = 1'b0;
   int  e_period = 0;
   int  last_cia_period = -1;
   bit  rand_bus = 1'b0, dma_alt = 1'b0;
   int  last_ack_cycle = 0;
   bit  ack_e_prev = 1'b0;

   always #5 clk = ~clk;

   gary_arb #(
      .CHIP_BLOCKS (CHIP_BLOCKS),
      .SLOW_BLOCKS (SLOW_BLOCKS),
      .NASTY_MAX   (NASTY_MAX)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .e          (e),
      .cpuaddress (cpuaddress),
      .cpureq     (cpureq),
      .cpurd      (cpurd),
      .cpuhwr     (cpuhwr),
      .cpulwr     (cpulwr),
      .cpuack     (cpuack),
      .dma        (dma),
      .dmawr      (dmawr),
      .dmapri     (dmapri),
      .ovl        (ovl),
      .boot       (boot),
      .rd         (rd),
      .hwr        (hwr),
      .lwr        (lwr),
      .selreg     (selreg),
      .selchip    (selchip),
      .selslow    (selslow),
      .selciaa    (selciaa),
      .selciab    (selciab),
      .selkick    (selkick),
      .selboot    (selboot),
      .berr       (berr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // region from the byte address ranges of the memory map
   function automatic int model_region(input logic [11:0] a, input logic ov, input logic bt);
      int addr;
      addr = int'(a) * 4096;
      if (addr >= 'hF80000) return R_KICK;
      if (addr < 'h200000) begin
         if (bt && addr < 'h1000) return R_BOOT;
         if (ov) return R_KICK;
         if (addr < CHIP_BLOCKS * 'h80000) return R_CHIP;
         return R_NONE;
      end
      if (addr >= 'hC00000 && addr < 'hC00000 + SLOW_BLOCKS * 'h80000) return R_SLOW;
      if (addr >= 'hC00000 && addr < 'hE00000) return R_REG;
      if (addr >= 'hA00000 && addr < 'hC00000) return R_CIA;
      return R_NONE;
   endfunction

   task automatic check_bus(input string tag);
      int r;
      logic [6:0] es, os;
      logic [2:0] ed, od;
      r  = model_region(cpuaddress, ovl, boot);
      es = {!dma && r == R_REG, dma || r == R_CHIP, !dma && r == R_SLOW,
            !dma && r == R_CIA && !cpuaddress[0], !dma && r == R_CIA && !cpuaddress[1],
            !dma && r == R_KICK, !dma && r == R_BOOT};
      os = {selreg, selchip, selslow, selciaa, selciab, selkick, selboot};
      chk({tag, "_sel"}, 32'(os), 32'(es));
      if (dma) ed = {!dmawr, dmawr, dmawr};
      else     ed = {cpurd && cpureq, cpuhwr && cpureq, cpulwr && cpureq};
      od = {rd, hwr, lwr};
      chk({tag, "_dir"}, 32'(od), 32'(ed));
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      e_prev = e;
      e_cnt  = (e_cnt + 1) % e_per;
      e      = e_run && (e_cnt < e_hi);
      if (e && !e_prev) e_period++;
      if (rand_bus) begin
         dma    = ($urandom_range(0, 99) < 25);
         dmawr  = 1'($urandom);
         dmapri = ($urandom_range(0, 99) < 50);
      end else if (dma_alt) begin
         dma = ~dma;
      end
      cycle++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_noack", 32'(cpuack), 32'd0);
         next_cycle();
      end
   endtask

   // one CPU access from the current (IDLE) cycle; returns request-to-ack latency
   task automatic run_txn(input string tag, input logic [11:0] a, output int lat);
      int  r, denied;
      bit  go, tmo, acked;
      cpuaddress = a;
      cpureq     = 1'b1;
      lat        = -1;
      denied     = 0;
      acked      = 1'b0;
      r          = model_region(a, ovl, boot);
      @(negedge clk);
      chk({tag, "_req_noack"}, 32'(cpuack), 32'd0);
      check_bus(tag);
      for (int w = 0; w < 400; w++) begin
         next_cycle();
         @(negedge clk);
         chk({tag, "_wait_noack"}, 32'(cpuack), 32'd0);
         chk({tag, "_wait_berr"}, 32'(berr), 32'd0);
         check_bus(tag);
         case (r)
            R_CHIP, R_REG: go = !dma && (!dmapri || denied == NASTY_MAX);
            R_SLOW:        go = !dma;
            R_CIA:         go = !dma && e && (e_period != last_cia_period);
            default:       go = 1'b1;
         endcase
         tmo = 1'b0;
`ifdef GARY_ARB_TIMEOUT_EN
         if (!go && w == 255) begin
            go  = 1'b1;
            tmo = 1'b1;
         end
`endif
         if (go) begin
            if (r == R_CIA && !tmo) last_cia_period = e_period;
            next_cycle();
            @(negedge clk);
            chk({tag, "_ack"}, 32'(cpuack), 32'd1);
            chk({tag, "_ack_berr"}, 32'(berr), 32'(tmo));
            check_bus(tag);
            lat            = w + 2;
            last_ack_cycle = cycle;
            ack_e_prev     = e_prev;
            acked          = 1'b1;
            break;
         end
         if ((r == R_CHIP || r == R_REG) && !dma && dmapri && denied < NASTY_MAX) denied++;
      end
      chk({tag, "_completed"}, 32'(acked), 32'd1);
      next_cycle();
      cpureq = 1'b0;
   endtask

   initial begin
      int lat, first_ack;
      logic [11:0] a;

      // reset held two cycles with a pending kickstart request
      cpuaddress = 12'hF80;
      cpureq     = 1'b1;
      cpurd      = 1'b1;
      next_cycle();
      @(negedge clk);
      chk("rst1_ack", 32'(cpuack), 32'd0);
      chk("rst1_berr", 32'(berr), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("rst2_ack", 32'(cpuack), 32'd0);
      next_cycle();
      reset = 1'b0;
      run_txn("rst_kick", 12'hF80, lat);
      chk("rst_kick_lat", 32'(lat), 32'd2);
      idle(1);

      // chip read, no contention
      run_txn("chip080", 12'h080, lat);
      chk("chip080_lat", 32'(lat), 32'd2);
      idle(1);
      // beyond configured chip RAM: no select, still completes
      run_txn("none100", 12'h100, lat);
      chk("none100_lat", 32'(lat), 32'd2);
      idle(1);

      // blitter priority held: fourth free slot
      dmapri = 1'b1;
      run_txn("nasty", 12'h040, lat);
      chk("nasty_lat", 32'(lat), 32'(NASTY_MAX + 2));
      idle(1);
      // dma interleaved: only free slots count
      dma     = 1'b0;
      dma_alt = 1'b1;
      run_txn("nasty_alt", 12'h040, lat);
      chk("nasty_alt_lat", 32'(lat), 32'(2 * NASTY_MAX + 3));
      dma_alt = 1'b0;
      dma     = 1'b0;
      idle(1);

      // abandoned chip request after two denied slots; the count must not carry over
      cpuaddress = 12'h040;
      cpureq     = 1'b1;
      idle(3);
      cpureq = 1'b0;
      idle(2);
      run_txn("nasty_fresh", 12'h040, lat);
      chk("nasty_fresh_lat", 32'(lat), 32'(NASTY_MAX + 2));
      dmapri = 1'b0;
      idle(1);

      // CIA with e one cycle in ten
      run_txn("cia", 12'hBFE, lat);
      @(negedge clk);
      chk("cia_selciaa", 32'(selciaa), 32'd1);
      chk("cia_selciab", 32'(selciab), 32'd0);
      chk("cia_after_e", 32'(ack_e_prev), 32'd1);
      idle(3);
      run_txn("cia_b2b1", 12'hBFE, lat);
      first_ack = last_ack_cycle;
      run_txn("cia_b2b2", 12'hBFD, lat);
      chk("cia_b2b_gap", 32'(last_ack_cycle - first_ack), 32'(e_per));
      idle(1);

      // overlay / boot decode
      ovl        = 1'b1;
      cpuaddress = 12'h000;
      @(negedge clk);
      chk("ovl_kick", 32'(selkick), 32'd1);
      check_bus("ovl");
      next_cycle();
      ovl  = 1'b0;
      boot = 1'b1;
      @(negedge clk);
      chk("boot_sel", 32'(selboot), 32'd1);
      check_bus("boot");
      next_cycle();
      cpuaddress = 12'h001;
      @(negedge clk);
      chk("boot_chip", 32'(selchip), 32'd1);
      check_bus("boot_chip");
      next_cycle();
      boot = 1'b0;

      // CIA request with e stuck low
      e_run = 1'b0;
      next_cycle();
`ifdef GARY_ARB_TIMEOUT_EN
      run_txn("tmo", 12'hBFE, lat);
      chk("tmo_lat", 32'(lat), 32'd257);
      idle(1);
`endif
      cpuaddress = 12'hBFE;
      cpureq     = 1'b1;
      for (int i = 0; i < HOLD; i++) begin
         @(negedge clk);
         chk("stuck_noack", 32'(cpuack), 32'd0);
         chk("stuck_noberr", 32'(berr), 32'd0);
         next_cycle();
      end
      cpureq = 1'b0;
      idle(3);

      // reset in the middle of a pending access
      cpureq = 1'b1;
      idle(3);
      reset = 1'b1;
      next_cycle();
      @(negedge clk);
      chk("midrst_ack", 32'(cpuack), 32'd0);
      chk("midrst_berr", 32'(berr), 32'd0);
      next_cycle();
      reset           = 1'b0;
      last_cia_period = -1;
      e_run           = 1'b1;
      run_txn("midrst_cia", 12'hBFE, lat);

      // randomized traffic; e high 5 of 12 so back-to-back CIA accesses collide
      e_per    = 12;
      e_hi     = 5;
      rand_bus = 1'b1;
      for (int t = 0; t < 150; t++) begin
         case ($urandom_range(0, 5))
            0:       a = 12'($urandom_range(0, 'h1FF));
            1:       a = 12'($urandom_range('hC00, 'hDFF));
            2:       a = 12'($urandom_range('hA00, 'hBFF));
            3:       a = 12'($urandom_range('hF80, 'hFFF));
            4:       a = 12'($urandom_range('h200, 'h9FF));
            default: a = 12'($urandom_range('hC00, 'hC7F));
         endcase
         ovl    = ($urandom_range(0, 9) == 0);
         boot   = ($urandom_range(0, 9) == 0);
         cpurd  = 1'($urandom);
         cpuhwr = !cpurd && 1'($urandom);
         cpulwr = !cpurd && 1'($urandom);
         run_txn("rnd", a, lat);
         idle($urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/gary_arb.md
Name: gary_arb

Overview:
- Parametrised successor to the chip-bus address decoder/arbiter.
- Decodes CPU addresses (chip RAM, slow RAM, custom registers, CIAs, Kickstart, boot ROM) and muxes CPU/Agnus bus direction signals.
- Replaces the purely combinational cpu-ok with a registered request/acknowledge handshake. Adds:
  - E-clock-aligned CIA access state machine;
  - blitter-nasty starvation counter;
  - configurable chip/slow RAM sizes.
- Sits between the CPU bus interface and Agnus/chip-bus peripherals.

Parameters:
- CHIP_BLOCKS, 2, number of 512KB chip RAM blocks at $000000 (legal 1-4).
- SLOW_BLOCKS, 1, number of 512KB slow RAM blocks from $C00000 (legal 0-3).
- NASTY_MAX, 3, consecutive dmapri-denied free slots before the CPU is forced one slot (legal 1-15).

Ports:
- clk in 1: bus clock
- reset in 1: synchronous, active-high
- e in 1: E clock level (one cycle high per E period is legal)
- cpuaddress in 12: CPU address [23:12]
- cpureq in 1: CPU access request, held until cpuack
- cpurd in 1: CPU read
- cpuhwr in 1: CPU high write
- cpulwr in 1: CPU low write
- cpuack out 1: one-cycle access-complete pulse
- dma in 1: Agnus owns current slot
- dmawr in 1: Agnus write
- dmapri in 1: blitter priority
- ovl in 1: Kickstart overlay
- boot in 1: boot ROM overlay
- rd out 1: bus read
- hwr out 1: bus high write
- lwr out 1: bus low write
- selreg out 1: custom register select
- selchip out 1: chip RAM select
- selslow out 1: slow RAM select
- selciaa out 1: CIA-A select
- selciab out 1: CIA-B select
- selkick out 1: Kickstart select
- selboot out 1: boot ROM select
- berr out 1: bus error pulse

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, named reset.
- Decode (combinational, from cpuaddress):
  - dma=1 forces selchip=1 and all other selects 0.
  - [23:19]=11111 → kick.
  - [23:21]=000 with boot=1 and [20:12]=0 → boot.
  - [23:21]=000 with ovl=1 → kick.
  - [23:21]=000 otherwise → chip if [20:19]<CHIP_BLOCKS, else none (no mirroring).
  - [23:19]-5'b11000 < SLOW_BLOCKS → slow.
  - Any other [23:21]=110 → reg.
  - [23:21]=101 → CIA: selciaa=!a[12], selciab=!a[13]; both may be set.
  - Everything else → none.
- Direction:
  - rd = dma ? ~dmawr : cpurd&cpureq
  - hwr = dma ? dmawr : cpuhwr&cpureq
  - lwr = dma ? dmawr : cpulwr&cpureq
- e_d: a register holding e delayed one cycle. A rising edge is detected as e & ~e_d.
- ciadone flag:
  - Set on a CIA ack.
  - Cleared when e=0.
  - Blocks a second CIA ack within the same E-high period.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: cpureq=1 → WAIT.
  - WAIT, per region, ack condition (satisfied → ACK; cpuack=1 during ACK for exactly 1 cycle):
    - kick / boot / none: unconditionally next cycle.
    - chip / reg: !dma && (!dmapri || nasty==NASTY_MAX).
    - slow: !dma.
    - CIA: !dma && e && !ciadone.
  - ACK → IDLE. cpureq is ignored for that cycle; back-to-back accesses therefore cost ≥3 cycles.
  - cpureq falling in WAIT → IDLE, no ack.
  - Address is re-decoded every cycle; the CPU must hold it stable while cpureq=1.
- nasty counter (4 bits):
  - Increments in WAIT for chip/reg when !dma && dmapri, saturating at NASTY_MAX.
  - Clears on any ack and in IDLE.
- Minimum latency cpureq→cpuack = 2 cycles. CIA worst case ≈ one E period plus DMA slots.
- Reset (including mid-access): state IDLE, cpuack=0, berr=0, nasty=0, ciadone=0, e_d=0, timeout=0. A pending request restarts from IDLE.

Optional Feature:
- Macro: GARY_ARB_TIMEOUT_EN.
- Defined:
  - 8-bit counter runs while in WAIT.
  - At 255, FSM → ACK with berr=1 in that same cycle; cpuack is also 1.
  - Counter clears on leaving WAIT.
- Undefined: berr tied 0, no counter.

Decomposition:
- gary_pkg holds:
  - region enum: RGN_NONE, RGN_CHIP, RGN_SLOW, RGN_REG, RGN_CIA, RGN_KICK, RGN_BOOT;
  - FSM state encoding;
  - decode field constants: 3'b000, 3'b101, 3'b110, 5'b11000, 5'b11111;
  - TIMEOUT_MAX=255.
- Sub-module gary_decode: pure combinational address→region plus select outputs, parametrised by CHIP_BLOCKS and SLOW_BLOCKS. The top holds the FSM, counters and direction mux.

Test Plan:
- Reset: assert reset 2 cycles with cpureq=1, release → cpuack=0 during reset; first ack in ≥2 cycles; nasty=0.
- Chip, CHIP_BLOCKS=2:
  - $080000 read, dma=0, dmapri=0 → selchip=1, cpuack exactly 2 cycles after cpureq.
  - $100000 → RGN_NONE; acked after 2 cycles, selchip=0.
- Nasty, NASTY_MAX=3, dmapri held 1, dma=0 → cpuack on the 4th free slot of WAIT. With dma=1 interleaved, only non-dma slots count.
- CIA:
  - $BFE001 with e pulsing 1-in-10 → selciaa=1, selciab=0, cpuack only in a cycle where e=1.
  - Two immediate requests → second ack a full E period later.
- Overlay: ovl=1, $000000 → selkick=1. boot=1, $000800 → selboot=1. boot=1, $001000 → selchip=1.
- Timeout (GARY_ARB_TIMEOUT_EN), $BFE001 with e stuck 0 → cpuack=1 and berr=1 in the same cycle, 256 cycles after WAIT entry.
